// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg
//   Shared types and helpers for the Wishbone bus arbiter slice.
//   - wb_arb_state_t : arbiter FSM states (ABORT only reachable when the
//                      WB_ARB_TIMEOUT_EN watchdog is compiled in)
//   - idx_w()        : ceil(log2(n)), never less than 1, for index widths
//   - WB_ARB_MAX_MASTERS : upper bound on the number of requesters
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_ABORT
  } wb_arb_state_t;

  localparam int WB_ARB_MAX_MASTERS = 8;

  function automatic int idx_w(int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// wb_rr_picker
//   Combinational round-robin picker. Scans requesters starting at the one
//   just after the last winner (wrapping) and returns the first one found.
// Ports
//   req     in  N         request vector
//   last    in  IW        index of the previous winner
//   winner  out N         one-hot winner (all zero when no request)
//   win_idx out IW        index of the winner (0 when no request)
module wb_rr_picker
  import wb_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] win_idx
);

  int   idx;
  logic found;

  always_comb begin
    winner  = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    // The last winner itself is checked last (offset N), so it only wins
    // when nobody else is asking.
    for (int off = 1; off <= N; off++) begin
      idx = (int'(last) + off) % N;
      if (!found && req[idx]) begin
        found       = 1'b1;
        winner[idx] = 1'b1;
        win_idx     = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter
//   Round-robin arbiter sharing one Wishbone initiator bus among
//   NUM_MASTERS requesters. The grant is held for the owner's whole cyc
//   tenure; a tenure ends when the owner drops m_cyc, leaving one idle
//   cycle before the next grant.
//   Optional feature macro: WB_ARB_TIMEOUT_EN (watchdog that errors the
//   owner and withdraws the bus after TIMEOUT_CYCLES stalled strobes).
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   m_cyc/m_stb/m_we [N]     per-master controls
//   m_adr [N*AW], m_dout [N*DW], m_sel [N*DW/8]  flattened per-master buses
//   m_din [DW]               read data broadcast (= s_din, never gated)
//   m_ack/m_err/m_rty [N]    responses routed to the owner only
//   s_cyc/s_stb/s_we, s_adr, s_dout, s_sel   shared slave-side bus
//   s_din, s_ack/s_err/s_rty slave responses
//   gnt [N]                  registered one-hot grant
//   busy                     high in BUSY or ABORT
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_MASTERS-1:0]                 m_cyc,
  input  logic [NUM_MASTERS-1:0]                 m_stb,
  input  logic [NUM_MASTERS-1:0]                 m_we,
  input  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0]   m_adr,
  input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0]   m_dout,
  input  logic [NUM_MASTERS*WB_DATA_WIDTH/8-1:0] m_sel,
  output logic [WB_DATA_WIDTH-1:0]               m_din,
  output logic [NUM_MASTERS-1:0]                 m_ack,
  output logic [NUM_MASTERS-1:0]                 m_err,
  output logic [NUM_MASTERS-1:0]                 m_rty,
  output logic                                   s_cyc,
  output logic                                   s_stb,
  output logic                                   s_we,
  output logic [WB_ADDR_WIDTH-1:0]               s_adr,
  output logic [WB_DATA_WIDTH-1:0]               s_dout,
  output logic [WB_DATA_WIDTH/8-1:0]             s_sel,
  input  logic [WB_DATA_WIDTH-1:0]               s_din,
  input  logic                                   s_ack,
  input  logic                                   s_err,
  input  logic                                   s_rty,
  output logic [NUM_MASTERS-1:0]                 gnt,
  output logic                                   busy
);

  localparam int N  = NUM_MASTERS;
  localparam int AW = WB_ADDR_WIDTH;
  localparam int DW = WB_DATA_WIDTH;
  localparam int SW = WB_DATA_WIDTH / 8;
  localparam int IW = idx_w(NUM_MASTERS);

  wb_arb_state_t state_reg;
  logic [N-1:0]  gnt_reg;
  logic [IW-1:0] last_reg;     // last winner == current owner while granted
  logic          busy_reg;

  logic [N-1:0]  pick_onehot;
  logic [IW-1:0] pick_idx;

  logic          mux_cyc, mux_stb, mux_we;
  logic [AW-1:0] mux_adr;
  logic [DW-1:0] mux_dout;
  logic [SW-1:0] mux_sel;
  logic          bus_live;
  logic          timeout_hit;

  wb_rr_picker #(.N(N)) u_picker (
    .req     (m_cyc),
    .last    (last_reg),
    .winner  (pick_onehot),
    .win_idx (pick_idx)
  );

  // AND-OR mux on the registered one-hot grant; everything is zero when
  // nobody is granted, so no extra gating is needed in IDLE or reset.
  always_comb begin
    mux_cyc  = 1'b0;
    mux_stb  = 1'b0;
    mux_we   = 1'b0;
    mux_adr  = '0;
    mux_dout = '0;
    mux_sel  = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_reg[i]) begin
        mux_cyc  = mux_cyc  | m_cyc[i];
        mux_stb  = mux_stb  | m_stb[i];
        mux_we   = mux_we   | m_we[i];
        mux_adr  = mux_adr  | m_adr[i*AW +: AW];
        mux_dout = mux_dout | m_dout[i*DW +: DW];
        mux_sel  = mux_sel  | m_sel[i*SW +: SW];
      end
    end
  end

  // The bus is only driven in BUSY; ABORT withdraws cyc/stb and ignores
  // any late slave response.
  assign bus_live = (state_reg == ARB_BUSY);

  assign s_cyc  = mux_cyc & bus_live;
  assign s_stb  = mux_stb & bus_live;
  assign s_we   = mux_we;
  assign s_adr  = mux_adr;
  assign s_dout = mux_dout;
  assign s_sel  = mux_sel;
  assign m_din  = s_din;

  assign m_ack = gnt_reg & {N{s_ack & bus_live}};
  assign m_rty = gnt_reg & {N{s_rty & bus_live}};
  assign m_err = gnt_reg & {N{(s_err & bus_live) | timeout_hit}};

  assign gnt  = gnt_reg;
  assign busy = busy_reg;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = idx_w(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wd_cnt_reg;
  logic          stalled;

  assign stalled = bus_live & mux_cyc & mux_stb & ~(s_ack | s_err | s_rty);
  // Fires in the stalled cycle that brings the count to TIMEOUT_CYCLES,
  // giving the owner its error pulse while the bus is still up.
  assign timeout_hit = stalled && (wd_cnt_reg == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_reg <= '0;
    end else if (!bus_live || s_ack || s_err || s_rty) begin
      // Holding zero outside BUSY makes every tenure start from a clean count.
      wd_cnt_reg <= '0;
    end else if (stalled && !timeout_hit) begin
      wd_cnt_reg <= wd_cnt_reg + CW'(1);
    end
  end
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ARB_IDLE;
      gnt_reg   <= '0;
      last_reg  <= IW'(N - 1);  // master 0 wins the first arbitration
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (|m_cyc) begin
            gnt_reg   <= pick_onehot;
            last_reg  <= pick_idx;
            state_reg <= ARB_BUSY;
            busy_reg  <= 1'b1;
          end
        end
        ARB_BUSY: begin
          if (!mux_cyc) begin
            gnt_reg   <= '0;
            state_reg <= ARB_IDLE;
            busy_reg  <= 1'b0;
          end else if (timeout_hit) begin
            state_reg <= ARB_ABORT;
          end
        end
        ARB_ABORT: begin
          // Grant is kept so the owner stays identified until it lets go.
          if (!mux_cyc) begin
            gnt_reg   <= '0;
            state_reg <= ARB_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          gnt_reg   <= '0;
          state_reg <= ARB_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb_wb_bus_arbiter
//   Directed bench for wb_bus_arbiter (4 masters, 32-bit address, 16-bit
//   data). Build with WB_ARB_TIMEOUT_EN defined to exercise the watchdog.
module tb_wb_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 16;
  localparam int SW = DW / 8;

  logic            clk;
  logic            rst;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dout;
  logic [N*SW-1:0] m_sel;
  logic [DW-1:0]   m_din;
  logic [N-1:0]    m_ack, m_err, m_rty;
  logic            s_cyc, s_stb, s_we;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dout;
  logic [SW-1:0]   s_sel;
  logic [DW-1:0]   s_din;
  logic            s_ack, s_err, s_rty;
  logic [N-1:0]    gnt;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  wb_bus_arbiter #(
    .NUM_MASTERS    (N),
    .WB_ADDR_WIDTH  (AW),
    .WB_DATA_WIDTH  (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .m_cyc  (m_cyc),
    .m_stb  (m_stb),
    .m_we   (m_we),
    .m_adr  (m_adr),
    .m_dout (m_dout),
    .m_sel  (m_sel),
    .m_din  (m_din),
    .m_ack  (m_ack),
    .m_err  (m_err),
    .m_rty  (m_rty),
    .s_cyc  (s_cyc),
    .s_stb  (s_stb),
    .s_we   (s_we),
    .s_adr  (s_adr),
    .s_dout (s_dout),
    .s_sel  (s_sel),
    .s_din  (s_din),
    .s_ack  (s_ack),
    .s_err  (s_err),
    .s_rty  (s_rty),
    .gnt    (gnt),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_cyc  = '0;
    m_stb  = '0;
    m_we   = '0;
    m_adr  = '0;
    m_dout = '0;
    m_sel  = '0;
    s_din  = '0;
    s_ack  = 1'b0;
    s_err  = 1'b0;
    s_rty  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    m_cyc = 4'b1111;
    m_stb = 4'b1111;
    s_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin n_fail++; $display("FAIL reset_scyc: got cyc=%b stb=%b want 0/0", s_cyc, s_stb); end
    n_checks++;
    if (m_ack !== 4'b0000) begin n_fail++; $display("FAIL reset_mack: got %b want 0000", m_ack); end
    clear_inputs();
    rst = 1'b0;
    step();
    $display("reset: gnt=%b busy=%b", gnt, busy);
  endtask

  task automatic test_single_write();
    do_reset();
    m_cyc = 4'b0001;
    m_stb = 4'b0001;
    m_we  = 4'b0001;
    m_adr[0*AW +: AW]  = 32'h0000_0010;
    m_dout[0*DW +: DW] = 16'h1234;
    m_sel[0*SW +: SW]  = 2'b11;
    #1;
    n_checks++;
    if (s_cyc !== 1'b0) begin n_fail++; $display("FAIL t1_latency: got s_cyc=%b want 0 before edge", s_cyc); end
    step();
    n_checks++;
    if (gnt !== 4'b0001) begin n_fail++; $display("FAIL t1_gnt: got %b want 0001", gnt); end
    n_checks++;
    if (s_cyc !== 1'b1 || s_stb !== 1'b1 || s_we !== 1'b1) begin
      n_fail++; $display("FAIL t1_ctrl: got cyc/stb/we=%b%b%b want 111", s_cyc, s_stb, s_we);
    end
    n_checks++;
    if (s_adr !== 32'h10 || s_dout !== 16'h1234 || s_sel !== 2'b11) begin
      n_fail++; $display("FAIL t1_bus: got adr=%h dout=%h sel=%b want 10/1234/11", s_adr, s_dout, s_sel);
    end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy: got %b want 1", busy); end
    s_ack = 1'b1;
    #1;
    n_checks++;
    if (m_ack !== 4'b0001) begin n_fail++; $display("FAIL t1_ack: got %b want 0001", m_ack); end
    step();
    s_ack = 1'b0;
    m_cyc = 4'b0000;
    m_stb = 4'b0000;
    #1;
    n_checks++;
    if (s_cyc !== 1'b0 || gnt !== 4'b0001) begin
      n_fail++; $display("FAIL t1_drop: got s_cyc=%b gnt=%b want 0/0001", s_cyc, gnt);
    end
    step();
    n_checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL t1_release: got gnt=%b busy=%b want 0000/0", gnt, busy);
    end
    $display("single write: master 0 adr=0x10 dout=0x1234 done");
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_gnt;
    int           owner;
    do_reset();
    for (int i = 0; i < N; i++) m_adr[i*AW +: AW] = 32'h100 + 32'(i);
    m_cyc = 4'b1111;
    m_stb = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      owner   = k % N;
      exp_gnt = 4'b0001 << owner;
      n_checks++;
      if (gnt !== exp_gnt || s_cyc !== 1'b1) begin
        n_fail++; $display("FAIL rr_gnt%0d: got gnt=%b s_cyc=%b want %b/1", k, gnt, s_cyc, exp_gnt);
      end
      n_checks++;
      if (s_adr !== 32'h100 + 32'(owner)) begin
        n_fail++; $display("FAIL rr_adr%0d: got %h want %h", k, s_adr, 32'h100 + 32'(owner));
      end
      s_ack = 1'b1;
      #1;
      n_checks++;
      if (m_ack !== exp_gnt) begin n_fail++; $display("FAIL rr_ack%0d: got %b want %b", k, m_ack, exp_gnt); end
      m_cyc[owner] = 1'b0;
      m_stb[owner] = 1'b0;
      step();
      s_ack = 1'b0;
      n_checks++;
      if (gnt !== 4'b0000 || s_cyc !== 1'b0) begin
        n_fail++; $display("FAIL rr_idle%0d: got gnt=%b s_cyc=%b want 0000/0", k, gnt, s_cyc);
      end
      m_cyc[owner] = 1'b1;
      m_stb[owner] = 1'b1;
      $display("rr tenure %0d: master %0d", k, owner);
      step();
    end
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_no_preempt();
    do_reset();
    m_adr[1*AW +: AW] = 32'h0000_0AAA;
    m_adr[2*AW +: AW] = 32'h0000_0222;
    m_cyc = 4'b0100;
    m_stb = 4'b0100;
    step();
    n_checks++;
    if (gnt !== 4'b0100) begin n_fail++; $display("FAIL np_gnt2: got %b want 0100", gnt); end
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (s_adr !== 32'h222 || gnt !== 4'b0100) begin
        n_fail++; $display("FAIL np_hold%0d: got adr=%h gnt=%b want 222/0100", c, s_adr, gnt);
      end
      step();
    end
    s_ack = 1'b1;
    #1;
    n_checks++;
    if (m_ack !== 4'b0100) begin n_fail++; $display("FAIL np_ack: got %b want 0100", m_ack); end
    m_cyc[2] = 1'b0;
    m_stb[2] = 1'b0;
    step();
    s_ack = 1'b0;
    n_checks++;
    if (gnt !== 4'b0000) begin n_fail++; $display("FAIL np_idle: got %b want 0000", gnt); end
    step();
    n_checks++;
    if (gnt !== 4'b0010 || s_adr !== 32'hAAA) begin
      n_fail++; $display("FAIL np_gnt1: got gnt=%b adr=%h want 0010/aaa", gnt, s_adr);
    end
    $display("no preempt: master 2 then master 1");
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_err_rty();
    do_reset();
    m_cyc = 4'b1000;
    m_stb = 4'b1000;
    step();
    n_checks++;
    if (gnt !== 4'b1000) begin n_fail++; $display("FAIL er_gnt: got %b want 1000", gnt); end
    s_err = 1'b1;
    #1;
    n_checks++;
    if (m_err !== 4'b1000 || m_ack !== 4'b0000 || m_rty !== 4'b0000) begin
      n_fail++; $display("FAIL er_err: got err=%b ack=%b rty=%b want 1000/0000/0000", m_err, m_ack, m_rty);
    end
    s_err = 1'b0;
    s_rty = 1'b1;
    #1;
    n_checks++;
    if (m_rty !== 4'b1000 || m_err !== 4'b0000) begin
      n_fail++; $display("FAIL er_rty: got rty=%b err=%b want 1000/0000", m_rty, m_err);
    end
    s_rty = 1'b0;
    s_din = 16'hCAFE;
    #1;
    n_checks++;
    if (m_din !== 16'hCAFE) begin n_fail++; $display("FAIL er_din: got %h want cafe", m_din); end
    $display("err/rty: master 3 routed err and rty");
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    m_cyc = 4'b0100;
    m_stb = 4'b0100;
    step();
    n_checks++;
    if (gnt !== 4'b0100 || s_cyc !== 1'b1) begin
      n_fail++; $display("FAIL ar_pre: got gnt=%b s_cyc=%b want 0100/1", gnt, s_cyc);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (s_cyc !== 1'b0 || s_stb !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ar_abort: got cyc=%b stb=%b gnt=%b busy=%b want 0/0/0000/0", s_cyc, s_stb, gnt, busy);
    end
    m_cyc = 4'b0101;
    m_stb = 4'b0101;
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if (gnt !== 4'b0001) begin n_fail++; $display("FAIL ar_first: got %b want 0001", gnt); end
    $display("async reset: next grant gnt=%b", gnt);
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_timeout();
    logic err_seen;
    do_reset();
    m_cyc = 4'b0001;
    m_stb = 4'b0001;
    step();
`ifdef WB_ARB_TIMEOUT_EN
    err_seen = 1'b0;
    for (int c = 1; c < 8; c++) begin
      if (m_err !== 4'b0000) err_seen = 1'b1;
      step();
    end
    n_checks++;
    if (err_seen) begin n_fail++; $display("FAIL to_early: got early m_err want none before cycle 8"); end
    n_checks++;
    if (m_err !== 4'b0001) begin n_fail++; $display("FAIL to_pulse: got %b want 0001", m_err); end
    step();
    n_checks++;
    if (s_cyc !== 1'b0 || m_err !== 4'b0000 || busy !== 1'b1 || gnt !== 4'b0001) begin
      n_fail++; $display("FAIL to_abort: got cyc=%b err=%b busy=%b gnt=%b want 0/0000/1/0001", s_cyc, m_err, busy, gnt);
    end
    m_cyc = 4'b0000;
    m_stb = 4'b0000;
    step();
    n_checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL to_idle: got gnt=%b busy=%b want 0000/0", gnt, busy);
    end
    $display("timeout: master 0 aborted after 8 stalled cycles");
`else
    err_seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (m_err !== 4'b0000) err_seen = 1'b1;
      step();
    end
    n_checks++;
    if (s_cyc !== 1'b1 || gnt !== 4'b0001 || busy !== 1'b1) begin
      n_fail++; $display("FAIL to_hold: got cyc=%b gnt=%b busy=%b want 1/0001/1", s_cyc, gnt, busy);
    end
    n_checks++;
    if (err_seen) begin n_fail++; $display("FAIL to_noerr: got m_err pulse want none"); end
    $display("no watchdog: bus held for 100 cycles");
`endif
    clear_inputs();
    step();
    step();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_write();
    test_round_robin();
    test_no_preempt();
    test_err_rty();
    test_async_reset();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
